// File: rtl/bcd_timekeeper_pkg.sv
// Shared constants and helpers for the BCD time-of-day counter.
// Covers the packed-time layout, the per-field limits and BCD arithmetic.
package bcd_timekeeper_pkg;

  localparam int TIME_W   = 32;

  localparam int HOUR_MSB = 31;
  localparam int HOUR_LSB = 24;
  localparam int MIN_MSB  = 23;
  localparam int MIN_LSB  = 16;
  localparam int SEC_MSB  = 15;
  localparam int SEC_LSB  = 8;
  localparam int MIL_MSB  = 7;
  localparam int MIL_LSB  = 0;

  localparam logic [7:0] HOUR_LIMIT = 8'h23;
  localparam logic [7:0] MIN_LIMIT  = 8'h59;
  localparam logic [7:0] SEC_LIMIT  = 8'h59;
  localparam logic [7:0] MIL_LIMIT  = 8'h99;

  // Next two-digit BCD value, ignoring any field limit.
  function automatic logic [7:0] bcd_step(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // Both digits decimal and the field no larger than its limit; digit-wise BCD
  // ordering matches numeric ordering once both digits are <= 9.
  function automatic logic bcd_field_ok(input logic [7:0] f, input logic [7:0] limit);
    return (f[3:0] <= 4'd9) && (f[7:4] <= 4'd9) && (f <= limit);
  endfunction

  function automatic logic time_valid(input logic [TIME_W-1:0] t);
    return bcd_field_ok(t[HOUR_MSB:HOUR_LSB], HOUR_LIMIT) &&
           bcd_field_ok(t[MIN_MSB:MIN_LSB],   MIN_LIMIT)  &&
           bcd_field_ok(t[SEC_MSB:SEC_LSB],   SEC_LIMIT)  &&
           bcd_field_ok(t[MIL_MSB:MIL_LSB],   MIL_LIMIT);
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter wrapping at LIMIT back to 00.
// Load has priority over increment, and a load suppresses the carry.
module bcd_mod_counter
  import bcd_timekeeper_pkg::*;
#(
  parameter logic [7:0] LIMIT = 8'h59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] d,
  output logic [7:0] q,
  output logic       carry
);

  logic [7:0] q_r;
  logic [7:0] q_next_s;
  logic       at_limit_s;

  assign at_limit_s = (q_r == LIMIT);
  // Carry is combinational so a whole chain advances in the same tick cycle.
  assign carry      = inc & ~load & at_limit_s;
  assign q          = q_r;

  // Next-value selection: load, wrap at limit, BCD increment, or hold.
  always_comb begin
    q_next_s = q_r;
    if (load) begin
      q_next_s = d;
    end else if (inc) begin
      if (at_limit_s) begin
        q_next_s = 8'h00;
      end else begin
        q_next_s = bcd_step(q_r);
      end
    end else begin
      q_next_s = q_r;
    end
  end

  // Field register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= 8'h00;
    end else begin
      q_r <= q_next_s;
    end
  end

endmodule

// File: rtl/bcd_timekeeper.sv
// Hours:minutes:seconds.hundredths BCD clock with a tick prescaler and
// validated parallel load; time_out, rollover and load_err are flop outputs.
module bcd_timekeeper
  import bcd_timekeeper_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TIME_W-1:0] time_in,
  input  logic              load,
  input  logic              run_en,
  output logic [TIME_W-1:0] time_out,
  output logic              rollover,
  output logic              load_err
);

  localparam int DIV  = CLK_HZ / TICK_HZ;
  localparam int PS_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PS_W-1:0] PS_TERM = PS_W'(DIV - 1);

  logic [PS_W-1:0] ps_r;
  logic [PS_W-1:0] ps_next_s;
  logic            load_ok_s;
  logic            load_bad_s;
  logic            tick_s;
  logic            rollover_r;
  logic            load_err_r;

  logic [7:0] hour_q_s, min_q_s, sec_q_s, mil_q_s;
  logic       hour_carry_s, min_carry_s, sec_carry_s, mil_carry_s;

  assign load_ok_s  = load & time_valid(time_in);
  assign load_bad_s = load & ~time_valid(time_in);
  // Any load (accepted or rejected) swallows a tick landing in the same cycle.
  assign tick_s     = run_en & ~load & (ps_r == PS_TERM);

  // Prescaler next state: cleared by an accepted load, frozen by a rejected one.
  always_comb begin
    ps_next_s = ps_r;
    if (load_ok_s) begin
      ps_next_s = '0;
    end else if (load_bad_s) begin
      ps_next_s = ps_r;
    end else if (run_en) begin
      if (ps_r == PS_TERM) begin
        ps_next_s = '0;
      end else begin
        ps_next_s = ps_r + PS_W'(1);
      end
    end else begin
      ps_next_s = ps_r;
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps_r <= '0;
    end else begin
      ps_r <= ps_next_s;
    end
  end

  bcd_mod_counter #(.LIMIT(MIL_LIMIT)) u_mil (
    .clk   (clk),
    .rst   (rst),
    .inc   (tick_s),
    .load  (load_ok_s),
    .d     (time_in[MIL_MSB:MIL_LSB]),
    .q     (mil_q_s),
    .carry (mil_carry_s)
  );

  bcd_mod_counter #(.LIMIT(SEC_LIMIT)) u_sec (
    .clk   (clk),
    .rst   (rst),
    .inc   (mil_carry_s),
    .load  (load_ok_s),
    .d     (time_in[SEC_MSB:SEC_LSB]),
    .q     (sec_q_s),
    .carry (sec_carry_s)
  );

  bcd_mod_counter #(.LIMIT(MIN_LIMIT)) u_min (
    .clk   (clk),
    .rst   (rst),
    .inc   (sec_carry_s),
    .load  (load_ok_s),
    .d     (time_in[MIN_MSB:MIN_LSB]),
    .q     (min_q_s),
    .carry (min_carry_s)
  );

  bcd_mod_counter #(.LIMIT(HOUR_LIMIT)) u_hour (
    .clk   (clk),
    .rst   (rst),
    .inc   (min_carry_s),
    .load  (load_ok_s),
    .d     (time_in[HOUR_MSB:HOUR_LSB]),
    .q     (hour_q_s),
    .carry (hour_carry_s)
  );

  // Status pulses, aligned with the time_out update they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rollover_r <= 1'b0;
      load_err_r <= 1'b0;
    end else begin
      rollover_r <= hour_carry_s;
      load_err_r <= load_bad_s;
    end
  end

  assign time_out = {hour_q_s, min_q_s, sec_q_s, mil_q_s};
  assign rollover = rollover_r;
  assign load_err = load_err_r;

endmodule
